// File: rtl/raster_scheduler_if.sv
// Scheduler-facing bundle: frame control, triangle-memory read port, rasterizer handshake and back-buffer clear port.
// master = scheduler side, slave = the surrounding frame/raster/memory logic.
interface raster_scheduler_if #(
  parameter int TRI_AW = 10
);
  logic                new_frame;
  logic [TRI_AW:0]     tri_count;
  logic [TRI_AW-1:0]   tri_addr;
  logic [80:0]         tri_rdata;
  logic [2:0][8:0]     vert1;
  logic [2:0][8:0]     vert2;
  logic [2:0][8:0]     vert3;
  logic                valid_tri;
  logic                rast_ready;
  logic                obj_done;
  logic                clear_we;
  logic [16:0]         clear_addr;
  logic                busy;
  logic                frame_overrun;

  modport master (
    input  new_frame, tri_count, tri_rdata, rast_ready,
    output tri_addr, vert1, vert2, vert3, valid_tri, obj_done,
           clear_we, clear_addr, busy, frame_overrun
  );

  modport slave (
    output new_frame, tri_count, tri_rdata, rast_ready,
    input  tri_addr, vert1, vert2, vert3, valid_tri, obj_done,
           clear_we, clear_addr, busy, frame_overrun
  );
endinterface

// File: rtl/raster_scheduler.sv
// Frame sequencer: optional back-buffer clear (RASTER_SCHED_CLEAR_EN), then fetch/issue triangles; first valid_tri 1+MEM_LAT+1 cycles after new_frame (+WIDTH*HEIGHT with clear).
// Backpressure: each triangle waits in ISSUE/WAIT for rast_ready with vertices held; new_frame while busy is dropped and flagged.
module raster_scheduler #(
  parameter int WIDTH   = 360,
  parameter int HEIGHT  = 360,
  parameter int TRI_AW  = 10,
  parameter int MEM_LAT = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  raster_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    ISSUE = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [16:0] CLR_LAST = 17'(WIDTH * HEIGHT - 1);
  localparam logic [2:0]  LAT_LAST = 3'(MEM_LAT - 1);
  localparam logic [TRI_AW:0] IDX_ONE = {{TRI_AW{1'b0}}, 1'b1};

  state_t            state;
  logic [TRI_AW:0]   idx;
  logic [TRI_AW:0]   count;
  logic [TRI_AW:0]   idx_nxt;
  logic [2:0]        lat_cnt;
  logic              blank;
  logic [TRI_AW-1:0] addr_r;
  logic [2:0][8:0]   v1_r;
  logic [2:0][8:0]   v2_r;
  logic [2:0][8:0]   v3_r;
  logic              obj_r;
  logic              busy_r;
  logic              clr_we_r;
  logic [16:0]       clr_addr_r;

  assign idx_nxt = idx + IDX_ONE;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      idx        <= '0;
      count      <= '0;
      lat_cnt    <= '0;
      blank      <= 1'b0;
      addr_r     <= '0;
      v1_r       <= '0;
      v2_r       <= '0;
      v3_r       <= '0;
      obj_r      <= 1'b0;
      busy_r     <= 1'b0;
      clr_we_r   <= 1'b0;
      clr_addr_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.new_frame) begin
            count   <= bus.tri_count;
            idx     <= '0;
            addr_r  <= '0;
            lat_cnt <= '0;
            busy_r  <= 1'b1;
`ifdef RASTER_SCHED_CLEAR_EN
            state      <= CLEAR;
            clr_we_r   <= 1'b1;
            clr_addr_r <= '0;
`else
            state <= FETCH;
`endif
          end
        end
`ifdef RASTER_SCHED_CLEAR_EN
        CLEAR: begin
          if (clr_addr_r == CLR_LAST) begin
            clr_we_r   <= 1'b0;
            clr_addr_r <= '0;
            state      <= FETCH;
          end else begin
            clr_addr_r <= clr_addr_r + 17'd1;
          end
        end
`endif
        FETCH: begin
          // Index check happens on the first FETCH cycle, so tri_count=0 skips memory entirely.
          if (idx == count) begin
            obj_r <= 1'b1;
            state <= DONE;
          end else if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            state   <= LOAD;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        LOAD: begin
          v1_r  <= bus.tri_rdata[26:0];
          v2_r  <= bus.tri_rdata[53:27];
          v3_r  <= bus.tri_rdata[80:54];
          state <= ISSUE;
        end
        ISSUE: begin
          if (bus.rast_ready) begin
            blank <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          // The rasterizer's ready lags valid_tri by a cycle; ignore it during the blanking cycle.
          if (blank) begin
            blank <= 1'b0;
          end else if (bus.rast_ready) begin
            idx    <= idx_nxt;
            addr_r <= idx_nxt[TRI_AW-1:0];
            state  <= FETCH;
          end
        end
        DONE: begin
          obj_r  <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          obj_r  <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.tri_addr      = addr_r;
  assign bus.vert1         = v1_r;
  assign bus.vert2         = v2_r;
  assign bus.vert3         = v3_r;
  assign bus.valid_tri     = (state == ISSUE) && bus.rast_ready;
  assign bus.obj_done      = obj_r;
  assign bus.busy          = busy_r;
  assign bus.frame_overrun = bus.new_frame && busy_r;

`ifdef RASTER_SCHED_CLEAR_EN
  assign bus.clear_we   = clr_we_r;
  assign bus.clear_addr = clr_addr_r;
`else
  logic unused_clr_cfg;
  assign unused_clr_cfg = ^{CLR_LAST, clr_we_r, clr_addr_r};
  assign bus.clear_we   = 1'b0;
  assign bus.clear_addr = '0;
`endif

endmodule
